// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external simple dual-port RAM with a
// one-cycle registered read. Words are written straight into the RAM. A
// three-state read engine (IDLE/FETCH/HOLD) prefetches the head word into an
// output register, so one word can be delivered every two cycles.
//
// Output handshake: dout is valid while dout_valid=1. dout and dout_valid stay
// stable until the consumer raises dout_ready. The word is taken on the rising
// edge where both are high.
module ram_fifo_ctrl #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [SIZE-1:0] push_data,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count,
  output logic [SIZE-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [AW-1:0]   ram_waddr,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  output logic [AW-1:0]   ram_raddr,
  input  logic [SIZE-1:0] ram_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        push_ok;
  logic        read_issue;

  // The extra pointer bit tells full (difference DEPTH) apart from empty (difference 0).
  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  // Gating with rst_n keeps the write enable low while reset is held.
  assign push_ok = push & ~full & ~flush & rst_n;

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Read FSM next state. A read is issued only when the RAM holds data.
  // Therefore the read address never meets a live write address.
  always_comb begin
    state_next = state;
    read_issue = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            read_issue = 1'b1;
            state_next = FETCH;
          end
        end
        FETCH: state_next = HOLD;
        HOLD: begin
          if (dout_ready) begin
            if (count != '0) begin
              read_issue = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Read FSM outputs and RAM port drive.
  always_comb begin
    ram_raddr      = rptr[AW-1:0];
    ram_waddr      = wptr[AW-1:0];
    ram_write_data = push_data;
    ram_write_en   = push_ok;
    empty          = (count == '0) && (state == IDLE);
  end

  // Write and read pointers. Flush overrides any push or read issue in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok)    wptr <= wptr + 1'b1;
      if (read_issue) rptr <= rptr + 1'b1;
    end
  end

  // Output stage. Flush leaves the stale dout word in place; only dout_valid is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      dout_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          dout       <= ram_read_data;
          dout_valid <= 1'b1;
        end
        HOLD: if (dout_ready) dout_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
